uart_tx: RTL and testbench

- Buffered 8N1 UART transmitter that drives the SOC's currently unused TXD pin; it is the transmit counterpart of the RXD input.
- The core side pushes bytes through a valid/ready write port into a small FIFO.
- A bit-timer state machine serialises each byte LSB-first.
- `o_busy` and `o_ready` are exposed so firmware can poll them through a memory-mapped status word.

---
 rtl/uart_tx.sv | 135 +++++++++++++
 tb/tb_uart_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO on a valid/ready write port
// feeding a bit-timer FSM that shifts each byte out LSB-first on o_txd.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [7:0]       i_data,
    output logic             o_ready,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_fifo_count,
    output logic             o_txd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    state_t           state_reg;
    logic [TMR_W-1:0] timer_reg;
    logic [2:0]       index_reg;
    logic [7:0]       shift_reg;
    logic             txd_reg;

    logic push;
    logic pop;
    logic timer_done;

    // Fullness is judged on the pre-edge count, so a pop on the same edge
    // never makes room for a write.
    assign push       = i_valid && (count_reg != FULL);
    assign timer_done = (timer_reg == '0);
    assign pop        = (count_reg != '0) &&
                        ((state_reg == IDLE) || ((state_reg == STOP) && timer_done));

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            state_reg  <= IDLE;
            timer_reg  <= '0;
            index_reg  <= '0;
            shift_reg  <= '0;
            txd_reg    <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                IDLE: begin
                    txd_reg <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr_reg];
                        timer_reg <= TMR_LOAD;
                        txd_reg   <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (timer_done) begin
                        txd_reg   <= shift_reg[0];
                        timer_reg <= TMR_LOAD;
                        index_reg <= '0;
                        state_reg <= DATA;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        timer_reg <= TMR_LOAD;
                        if (index_reg == 3'd7) begin
                            txd_reg   <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            txd_reg   <= shift_reg[1];
                            index_reg <= index_reg + 1'b1;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                STOP: begin
                    if (timer_done) begin
                        // Chain straight into the next start bit when data is waiting.
                        if (pop) begin
                            shift_reg <= mem[rd_ptr_reg];
                            timer_reg <= TMR_LOAD;
                            txd_reg   <= 1'b0;
                            state_reg <= START;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_ready      = (count_reg != FULL);
    assign o_busy       = (state_reg != IDLE) || (count_reg != '0);
    assign o_fifo_count = count_reg;
    assign o_txd        = txd_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 4 clocks per bit: a line monitor decodes frames
// from o_txd while table vectors and hand-written sequences check timing and FIFO.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       busy;
    logic [2:0] fifo_count;
    logic       txd;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_valid      (valid),
        .i_data       (data),
        .o_ready      (ready),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_txd        (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    // Line monitor: sample every cycle of a frame; each bit must hold CPB cycles.
    logic [9:0] rx_frame_q [$];
    bit         rx_shape_q [$];
    int         rx_start_q [$];

    initial begin : monitor
        logic        prev;
        logic [39:0] samp;
        logic [9:0]  fr;
        bit          in_frame;
        bit          shape;
        int          phase;
        int          st;
        prev     = 1'b1;
        in_frame = 0;
        phase    = 0;
        st       = 0;
        samp     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 0;
            end else if (!in_frame) begin
                if (prev && !txd) begin
                    in_frame = 1;
                    phase    = 0;
                    samp[0]  = 1'b0;
                    st       = cyc;
                end
            end else begin
                phase++;
                samp[phase] = txd;
                if (phase == 10 * CPB - 1) begin
                    shape = 1;
                    for (int k = 0; k < 10; k++) begin
                        fr[k] = samp[4*k];
                        for (int j = 1; j < CPB; j++)
                            if (samp[4*k+j] !== samp[4*k]) shape = 0;
                    end
                    rx_frame_q.push_back(fr);
                    rx_shape_q.push_back(shape);
                    rx_start_q.push_back(st);
                    in_frame = 0;
                end
            end
            prev = txd;
        end
    end

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;   // bit0 start, bits1..8 data LSB-first, bit9 stop
        int         lat;     // edges from the write edge to busy low
    } vec_t;

    vec_t vecs [7];

    task automatic wait_idle(input int limit, output int n);
        n = 0;
        while (busy && n < limit) begin
            data = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_single(input vec_t v, input int idx);
        int base;
        int n;
        base  = rx_frame_q.size();
        valid = 1'b1;
        data  = v.d;
        @(posedge clk); #1;
        valid = 1'b0;
        check($sformatf("v%0d_count_after_write", idx), 32'(fifo_count), 32'd1);
        check($sformatf("v%0d_busy_after_write", idx), 32'(busy), 32'd1);
        @(posedge clk); #1;
        check($sformatf("v%0d_start_bit", idx), 32'(txd), 32'd0);
        check($sformatf("v%0d_count_after_pop", idx), 32'(fifo_count), 32'd0);
        wait_idle(200, n);
        check($sformatf("v%0d_busy_latency", idx), 32'(n + 1), 32'(v.lat));
        check($sformatf("v%0d_frames", idx), 32'(rx_frame_q.size()), 32'(base + 1));
        if (rx_frame_q.size() > base) begin
            check($sformatf("v%0d_frame", idx), 32'(rx_frame_q[base]), 32'(v.frame));
            check($sformatf("v%0d_bit_hold", idx), 32'(rx_shape_q[base]), 32'd1);
        end
        check($sformatf("v%0d_txd_idle", idx), 32'(txd), 32'd1);
    endtask

    initial begin : main
        int   base;
        int   n;
        bit   flag;
        logic [9:0] exp_fr [5];

        vecs[0] = '{8'h55, 10'h2AA, 41};
        vecs[1] = '{8'hA3, 10'h346, 41};
        vecs[2] = '{8'h0F, 10'h21E, 41};
        vecs[3] = '{8'h00, 10'h200, 41};
        vecs[4] = '{8'hFF, 10'h3FE, 41};
        vecs[5] = '{8'h80, 10'h300, 41};
        vecs[6] = '{8'h01, 10'h202, 41};

        rst   = 1'b1;
        valid = 1'b0;
        data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;

        // Idle with garbage on i_data and valid low.
        flag = 1;
        repeat (50) begin
            data = 8'($urandom);
            @(posedge clk); #1;
            if (txd !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) flag = 0;
        end
        check("idle50_stable", 32'(flag), 32'd1);

        for (int i = 0; i < 7; i++) run_single(vecs[i], i);

        // Back-to-back frames with no idle gap.
        base  = rx_frame_q.size();
        valid = 1'b1;
        data  = 8'hA3;
        @(posedge clk); #1;
        data  = 8'h0F;
        @(posedge clk); #1;
        valid = 1'b0;
        wait_idle(300, n);
        check("b2b_frames", 32'(rx_frame_q.size()), 32'(base + 2));
        if (rx_frame_q.size() >= base + 2) begin
            check("b2b_frame0", 32'(rx_frame_q[base]), 32'h346);
            check("b2b_frame1", 32'(rx_frame_q[base+1]), 32'h21E);
            check("b2b_gap", 32'(rx_start_q[base+1] - rx_start_q[base]), 32'(10 * CPB));
        end

        // Fill while the FSM is busy, then hold a write through the STOP->START pop.
        base = rx_frame_q.size();
        for (int i = 1; i <= 5; i++) begin
            valid = 1'b1;
            data  = 8'(i);
            @(posedge clk); #1;
        end
        check("fill_count_full", 32'(fifo_count), 32'd4);
        check("fill_ready_low", 32'(ready), 32'd0);
        data = 8'h06;
        flag = 1;
        repeat (36) begin
            @(posedge clk); #1;
            if (ready !== 1'b0 || fifo_count !== 3'd4) flag = 0;
        end
        check("full_hold", 32'(flag), 32'd1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("full_pop_count", 32'(fifo_count), 32'd3);
        check("full_pop_ready", 32'(ready), 32'd1);
        wait_idle(400, n);
        exp_fr = '{10'h202, 10'h204, 10'h206, 10'h208, 10'h20A};
        check("fill_frames", 32'(rx_frame_q.size()), 32'(base + 5));
        if (rx_frame_q.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("fill_frame%0d", i), 32'(rx_frame_q[base+i]), 32'(exp_fr[i]));
                check($sformatf("fill_hold%0d", i), 32'(rx_shape_q[base+i]), 32'd1);
            end
            check("fill_gap", 32'(rx_start_q[base+4] - rx_start_q[base+3]), 32'(10 * CPB));
        end

        // Reset during data bit 3 of 0xFF with two bytes queued.
        base  = rx_frame_q.size();
        valid = 1'b1;
        data  = 8'hFF;
        @(posedge clk); #1;
        data  = 8'h11;
        @(posedge clk); #1;
        data  = 8'h22;
        @(posedge clk); #1;
        valid = 1'b0;
        check("abort_count_pre", 32'(fifo_count), 32'd2);
        repeat (15) @(posedge clk);
        #1;
        check("abort_txd_pre", 32'(txd), 32'd1);
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_txd", 32'(txd), 32'd1);
        check("abort_count", 32'(fifo_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd1);
        flag = 1;
        repeat (60) begin
            @(posedge clk); #1;
            if (txd !== 1'b1 || busy !== 1'b0) flag = 0;
        end
        check("abort_quiet", 32'(flag), 32'd1);
        check("abort_no_frames", 32'(rx_frame_q.size()), 32'(base));

        run_single('{8'h5A, 10'h2B4, 41}, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
